// File: rtl/uart_pkg.sv
// Shared constants for the UART packet controller: default SOF marker,
// error codes and FSM state encoding.
package uart_pkg;

   localparam logic [7:0] SOF_DEFAULT = 8'hA5;

   localparam logic [1:0] LEN_ERR     = 2'd0;
   localparam logic [1:0] CSUM_ERR    = 2'd1;
   localparam logic [1:0] TIMEOUT_ERR = 2'd2;
   localparam logic [1:0] OVR_ERR     = 2'd3;

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_LEN     = 3'd1;
   localparam logic [2:0] S_PAYLOAD = 3'd2;
   localparam logic [2:0] S_CSUM    = 3'd3;
   localparam logic [2:0] S_DONE    = 3'd4;

   typedef enum logic [2:0] {
      IDLE    = S_IDLE,
      LEN     = S_LEN,
      PAYLOAD = S_PAYLOAD,
      CSUM    = S_CSUM,
      DONE    = S_DONE
   } state_e;

endpackage

// File: rtl/uart_pkt_ctrl_if.sv
// Receiver-side byte inputs plus the consumer-side packet/read/error signals.
interface uart_pkt_ctrl_if #(
   parameter int AW = 4
) ();
   logic [7:0]  rx_data;
   logic        rx_busy;
   logic        pkt_ack;
   logic [AW-1:0] rd_addr;
   logic [7:0]  rd_data;
   logic        pkt_valid;
   logic [AW:0] pkt_len;
   logic        err_pulse;
   logic [1:0]  err_code;

   modport slave (
      input  rx_data, rx_busy, pkt_ack, rd_addr,
      output rd_data, pkt_valid, pkt_len, err_pulse, err_code
   );

   modport master (
      output rx_data, rx_busy, pkt_ack, rd_addr,
      input  rd_data, pkt_valid, pkt_len, err_pulse, err_code
   );
endinterface

// File: rtl/uart_pkt_buf.sv
// Payload storage: one synchronous write port, one asynchronous read port.
// Contents are not reset; only committed packets are ever read out.
module uart_pkt_buf #(
   parameter int DEPTH = 16,
   parameter int AW    = 4
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [7:0]    wdata,
   input  logic [AW-1:0] rd_addr,
   output logic [7:0]    rd_data
);
   logic [7:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   assign rd_data = mem[rd_addr];
endmodule

// File: rtl/uart_pkt_ctrl.sv
// Frame parser behind the UART receiver: SOF, LEN, payload, XOR checksum.
// Commits a packet with level valid/ack and strobes length/csum/timeout/overrun errors.
module uart_pkt_ctrl
   import uart_pkg::*;
#(
   parameter logic [7:0]  SOF_BYTE = SOF_DEFAULT,
   parameter int          MAX_LEN  = 16,
   parameter logic [15:0] TIMEOUT  = 16'd2000,
   parameter int          AW       = 4
) (
   input  logic            baud_clk,
   input  logic            reset,
   uart_pkt_ctrl_if.slave  bus
);
   localparam logic [7:0]  MAX_LEN8 = 8'(MAX_LEN);
   localparam logic [15:0] TMO_LAST = TIMEOUT - 16'd1;

   state_e        state_q, state_d;
   logic          rx_busy_d_q;
   logic [AW:0]   len_q, len_d;
   logic [AW-1:0] cnt_q, cnt_d;
   logic [7:0]    csum_q, csum_d;
   logic [15:0]   tmo_q, tmo_d;
   logic          pkt_valid_q, pkt_valid_d;
   logic [AW:0]   pkt_len_q, pkt_len_d;
   logic          err_pulse_q, err_pulse_d;
   logic [1:0]    err_code_q, err_code_d;

   logic          byte_stb;
   logic          tmo_active;
   logic          tmo_hit;
   logic          last_payload;
   logic          we;

   assign byte_stb     = rx_busy_d_q & ~bus.rx_busy;
   assign tmo_active   = (state_q == LEN) || (state_q == PAYLOAD) || (state_q == CSUM);
   assign tmo_hit      = tmo_active && (tmo_q == TMO_LAST);
   assign last_payload = ({1'b0, cnt_q} == (len_q - {{AW{1'b0}}, 1'b1}));

   always_comb begin
      state_d     = state_q;
      len_d       = len_q;
      cnt_d       = cnt_q;
      csum_d      = csum_q;
      pkt_valid_d = pkt_valid_q;
      pkt_len_d   = pkt_len_q;
      err_pulse_d = 1'b0;
      err_code_d  = err_code_q;
      we          = 1'b0;
      // A strobe always beats a coincident timeout, so clear before testing tmo_hit.
      tmo_d       = (byte_stb || !tmo_active) ? 16'd0 : tmo_q + 16'd1;

      case (state_q)
         IDLE: begin
            if (byte_stb && bus.rx_data == SOF_BYTE) state_d = LEN;
         end
         LEN: begin
            if (byte_stb) begin
               if (bus.rx_data == 8'd0 || bus.rx_data > MAX_LEN8) begin
                  err_pulse_d = 1'b1;
                  err_code_d  = LEN_ERR;
                  state_d     = IDLE;
               end else begin
                  len_d   = bus.rx_data[AW:0];
                  csum_d  = bus.rx_data;
                  cnt_d   = '0;
                  state_d = PAYLOAD;
               end
            end else if (tmo_hit) begin
               err_pulse_d = 1'b1;
               err_code_d  = TIMEOUT_ERR;
               state_d     = IDLE;
            end
         end
         PAYLOAD: begin
            if (byte_stb) begin
               we     = 1'b1;
               csum_d = csum_q ^ bus.rx_data;
               cnt_d  = cnt_q + 1'b1;
               if (last_payload) state_d = CSUM;
            end else if (tmo_hit) begin
               err_pulse_d = 1'b1;
               err_code_d  = TIMEOUT_ERR;
               state_d     = IDLE;
            end
         end
         CSUM: begin
            if (byte_stb) begin
               if (bus.rx_data == csum_q) begin
                  pkt_valid_d = 1'b1;
                  pkt_len_d   = len_q;
                  state_d     = DONE;
               end else begin
                  err_pulse_d = 1'b1;
                  err_code_d  = CSUM_ERR;
                  state_d     = IDLE;
               end
            end else if (tmo_hit) begin
               err_pulse_d = 1'b1;
               err_code_d  = TIMEOUT_ERR;
               state_d     = IDLE;
            end
         end
         DONE: begin
            if (bus.pkt_ack) begin
               pkt_valid_d = 1'b0;
               state_d     = IDLE;
            end
            // Bytes arriving while a packet is held are dropped, ack or not.
            if (byte_stb) begin
               err_pulse_d = 1'b1;
               err_code_d  = OVR_ERR;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge baud_clk) begin
      if (reset) begin
         state_q     <= IDLE;
         rx_busy_d_q <= 1'b0;
         len_q       <= '0;
         cnt_q       <= '0;
         csum_q      <= '0;
         tmo_q       <= '0;
         pkt_valid_q <= 1'b0;
         pkt_len_q   <= '0;
         err_pulse_q <= 1'b0;
         err_code_q  <= '0;
      end else begin
         state_q     <= state_d;
         rx_busy_d_q <= bus.rx_busy;
         len_q       <= len_d;
         cnt_q       <= cnt_d;
         csum_q      <= csum_d;
         tmo_q       <= tmo_d;
         pkt_valid_q <= pkt_valid_d;
         pkt_len_q   <= pkt_len_d;
         err_pulse_q <= err_pulse_d;
         err_code_q  <= err_code_d;
      end
   end

   uart_pkt_buf #(
      .DEPTH (MAX_LEN),
      .AW    (AW)
   ) u_buf (
      .clk     (baud_clk),
      .we      (we),
      .waddr   (cnt_q),
      .wdata   (bus.rx_data),
      .rd_addr (bus.rd_addr),
      .rd_data (bus.rd_data)
   );

   assign bus.pkt_valid = pkt_valid_q;
   assign bus.pkt_len   = pkt_len_q;
   assign bus.err_pulse = err_pulse_q;
   assign bus.err_code  = err_code_q;
endmodule

// File: tb/tb_uart_pkt_ctrl.sv
// Directed bench for uart_pkt_ctrl: drives receiver bytes as busy-flag falls
// and checks packet commit, readback and each error path against hand values.
module tb_uart_pkt_ctrl;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_chk = 0;
   int   n_fail = 0;
   int   err_seen = 0;

   uart_pkt_ctrl_if #(.AW(4)) bus ();

   uart_pkt_ctrl #(
      .SOF_BYTE (8'hA5),
      .MAX_LEN  (16),
      .TIMEOUT  (16'd2000),
      .AW       (4)
   ) dut (
      .baud_clk (clk),
      .reset    (rst),
      .bus      (bus)
   );

   always #5 clk = ~clk;

   always @(negedge clk) if (bus.err_pulse === 1'b1) err_seen++;

   // Busy for one cycle, then data lands as busy falls; returns just after the strobe edge.
   task automatic send_byte(input logic [7:0] b, input logic ack);
      bus.rx_busy = 1'b1;
      @(posedge clk); #1;
      bus.rx_data = b;
      bus.rx_busy = 1'b0;
      bus.pkt_ack = ack;
      @(posedge clk); #1;
      bus.pkt_ack = 1'b0;
   endtask

   task automatic do_ack();
      bus.pkt_ack = 1'b1;
      @(posedge clk); #1;
      bus.pkt_ack = 1'b0;
   endtask

   task automatic test_reset();
      bus.rx_busy = 1'b0; bus.rx_data = 8'h00; bus.pkt_ack = 1'b0; bus.rd_addr = '0;
      rst = 1'b1;
      repeat (3) @(posedge clk); #1;
      n_chk++; if (bus.pkt_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", bus.pkt_valid); end
      n_chk++; if (bus.pkt_len !== 5'd0) begin n_fail++; $display("FAIL reset_len got %0d want 0", bus.pkt_len); end
      n_chk++; if (bus.err_pulse !== 1'b0) begin n_fail++; $display("FAIL reset_errp got %b want 0", bus.err_pulse); end
      n_chk++; if (bus.err_code !== 2'd0) begin n_fail++; $display("FAIL reset_code got %0d want 0", bus.err_code); end
      rst = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_good_frame();
      logic [7:0] exp [3];
      int e0;
      exp[0] = 8'h11; exp[1] = 8'h22; exp[2] = 8'h33;
      e0 = err_seen;
      send_byte(8'hA5, 1'b0); send_byte(8'h03, 1'b0);
      send_byte(8'h11, 1'b0); send_byte(8'h22, 1'b0); send_byte(8'h33, 1'b0);
      n_chk++; if (bus.pkt_valid !== 1'b0) begin n_fail++; $display("FAIL good_early_valid got %b want 0", bus.pkt_valid); end
      send_byte(8'h03, 1'b0);
      n_chk++; if (bus.pkt_valid !== 1'b1) begin n_fail++; $display("FAIL good_valid got %b want 1", bus.pkt_valid); end
      n_chk++; if (bus.pkt_len !== 5'd3) begin n_fail++; $display("FAIL good_len got %0d want 3", bus.pkt_len); end
      for (int i = 0; i < 3; i++) begin
         bus.rd_addr = 4'(i); #1;
         n_chk++; if (bus.rd_data !== exp[i]) begin n_fail++; $display("FAIL good_rd%0d got %h want %h", i, bus.rd_data, exp[i]); end
      end
      n_chk++; if (err_seen !== e0) begin n_fail++; $display("FAIL good_noerr got %0d pulses want 0", err_seen - e0); end
      do_ack();
      n_chk++; if (bus.pkt_valid !== 1'b0) begin n_fail++; $display("FAIL good_ack got %b want 0", bus.pkt_valid); end
   endtask

   task automatic test_bad_csum();
      int e0;
      e0 = err_seen;
      send_byte(8'h00, 1'b0); send_byte(8'hFF, 1'b0);
      n_chk++; if (err_seen !== e0) begin n_fail++; $display("FAIL noise_ignored got %0d pulses want 0", err_seen - e0); end
      send_byte(8'hA5, 1'b0); send_byte(8'h02, 1'b0);
      send_byte(8'h10, 1'b0); send_byte(8'h20, 1'b0); send_byte(8'h00, 1'b0);
      n_chk++; if (bus.err_pulse !== 1'b1) begin n_fail++; $display("FAIL csum_errp got %b want 1", bus.err_pulse); end
      n_chk++; if (bus.err_code !== 2'd1) begin n_fail++; $display("FAIL csum_code got %0d want 1", bus.err_code); end
      n_chk++; if (bus.pkt_valid !== 1'b0) begin n_fail++; $display("FAIL csum_valid got %b want 0", bus.pkt_valid); end
      @(posedge clk); #1;
      n_chk++; if (bus.err_pulse !== 1'b0) begin n_fail++; $display("FAIL csum_pulse_width got %b want 0", bus.err_pulse); end
      send_byte(8'hA5, 1'b0); send_byte(8'h01, 1'b0); send_byte(8'h42, 1'b0); send_byte(8'h43, 1'b0);
      bus.rd_addr = 4'd0; #1;
      n_chk++; if (bus.pkt_valid !== 1'b1) begin n_fail++; $display("FAIL after_bad_valid got %b want 1", bus.pkt_valid); end
      n_chk++; if (bus.rd_data !== 8'h42) begin n_fail++; $display("FAIL after_bad_rd got %h want 42", bus.rd_data); end
      do_ack();
   endtask

   task automatic test_len_bounds();
      send_byte(8'hA5, 1'b0); send_byte(8'h00, 1'b0);
      n_chk++; if (bus.err_pulse !== 1'b1 || bus.err_code !== 2'd0) begin n_fail++; $display("FAIL len0 got pulse %b code %0d want 1/0", bus.err_pulse, bus.err_code); end
      send_byte(8'hA5, 1'b0); send_byte(8'h11, 1'b0);
      n_chk++; if (bus.err_pulse !== 1'b1 || bus.err_code !== 2'd0) begin n_fail++; $display("FAIL len17 got pulse %b code %0d want 1/0", bus.err_pulse, bus.err_code); end
      send_byte(8'hA5, 1'b0); send_byte(8'h10, 1'b0);
      for (int i = 0; i < 16; i++) send_byte(8'h10 + 8'(i), 1'b0);
      send_byte(8'h10, 1'b0);
      n_chk++; if (bus.pkt_valid !== 1'b1) begin n_fail++; $display("FAIL len16_valid got %b want 1", bus.pkt_valid); end
      n_chk++; if (bus.pkt_len !== 5'd16) begin n_fail++; $display("FAIL len16_len got %0d want 16", bus.pkt_len); end
      bus.rd_addr = 4'd0; #1;
      n_chk++; if (bus.rd_data !== 8'h10) begin n_fail++; $display("FAIL len16_rd0 got %h want 10", bus.rd_data); end
      bus.rd_addr = 4'd15; #1;
      n_chk++; if (bus.rd_data !== 8'h1F) begin n_fail++; $display("FAIL len16_rd15 got %h want 1f", bus.rd_data); end
      do_ack();
   endtask

   task automatic test_timeout();
      int e0;
      send_byte(8'hA5, 1'b0); send_byte(8'h02, 1'b0); send_byte(8'hAA, 1'b0);
      e0 = err_seen;
      repeat (1999) @(posedge clk); #1;
      n_chk++; if (bus.err_pulse !== 1'b0 || err_seen !== e0) begin n_fail++; $display("FAIL tmo_early got pulse %b count %0d want 0/0", bus.err_pulse, err_seen - e0); end
      @(posedge clk); #1;
      n_chk++; if (bus.err_pulse !== 1'b1 || bus.err_code !== 2'd2) begin n_fail++; $display("FAIL tmo_fire got pulse %b code %0d want 1/2", bus.err_pulse, bus.err_code); end
      send_byte(8'hA5, 1'b0); send_byte(8'h01, 1'b0); send_byte(8'h55, 1'b0); send_byte(8'h54, 1'b0);
      n_chk++; if (bus.pkt_valid !== 1'b1) begin n_fail++; $display("FAIL tmo_recover got %b want 1", bus.pkt_valid); end
      do_ack();
      send_byte(8'hA5, 1'b0); send_byte(8'h02, 1'b0); send_byte(8'hAA, 1'b0);
      e0 = err_seen;
      repeat (1997) @(posedge clk); #1;
      send_byte(8'hBB, 1'b0);
      send_byte(8'h13, 1'b0);
      bus.rd_addr = 4'd1; #1;
      n_chk++; if (bus.pkt_valid !== 1'b1 || err_seen !== e0) begin n_fail++; $display("FAIL tmo_1999 got valid %b pulses %0d want 1/0", bus.pkt_valid, err_seen - e0); end
      n_chk++; if (bus.rd_data !== 8'hBB) begin n_fail++; $display("FAIL tmo_1999_rd got %h want bb", bus.rd_data); end
      do_ack();
   endtask

   task automatic test_overrun();
      send_byte(8'hA5, 1'b0); send_byte(8'h01, 1'b0); send_byte(8'h66, 1'b0); send_byte(8'h67, 1'b0);
      send_byte(8'h55, 1'b0);
      bus.rd_addr = 4'd0; #1;
      n_chk++; if (bus.err_pulse !== 1'b1 || bus.err_code !== 2'd3) begin n_fail++; $display("FAIL ovr got pulse %b code %0d want 1/3", bus.err_pulse, bus.err_code); end
      n_chk++; if (bus.pkt_valid !== 1'b1) begin n_fail++; $display("FAIL ovr_valid got %b want 1", bus.pkt_valid); end
      n_chk++; if (bus.rd_data !== 8'h66) begin n_fail++; $display("FAIL ovr_buf got %h want 66", bus.rd_data); end
      do_ack();
      send_byte(8'hA5, 1'b0); send_byte(8'h00, 1'b0);
      send_byte(8'hA5, 1'b0); send_byte(8'h01, 1'b0); send_byte(8'h12, 1'b0); send_byte(8'h13, 1'b0);
      send_byte(8'h77, 1'b1);
      n_chk++; if (bus.pkt_valid !== 1'b0) begin n_fail++; $display("FAIL sim_valid got %b want 0", bus.pkt_valid); end
      n_chk++; if (bus.err_pulse !== 1'b1 || bus.err_code !== 2'd3) begin n_fail++; $display("FAIL sim_err got pulse %b code %0d want 1/3", bus.err_pulse, bus.err_code); end
      send_byte(8'hA5, 1'b0); send_byte(8'h01, 1'b0); send_byte(8'h21, 1'b0); send_byte(8'h20, 1'b0);
      bus.rd_addr = 4'd0; #1;
      n_chk++; if (bus.pkt_valid !== 1'b1 || bus.rd_data !== 8'h21) begin n_fail++; $display("FAIL sim_next got valid %b rd %h want 1/21", bus.pkt_valid, bus.rd_data); end
   endtask

   task automatic test_reset_mid();
      send_byte(8'h66, 1'b1);
      send_byte(8'hA5, 1'b0); send_byte(8'h04, 1'b0); send_byte(8'h01, 1'b0);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      n_chk++; if (bus.pkt_valid !== 1'b0 || bus.pkt_len !== 5'd0 || bus.err_pulse !== 1'b0 || bus.err_code !== 2'd0) begin
         n_fail++; $display("FAIL midreset got valid %b len %0d pulse %b code %0d want all 0", bus.pkt_valid, bus.pkt_len, bus.err_pulse, bus.err_code);
      end
      send_byte(8'hA5, 1'b0); send_byte(8'h01, 1'b0); send_byte(8'h7E, 1'b0); send_byte(8'h7F, 1'b0);
      bus.rd_addr = 4'd0; #1;
      n_chk++; if (bus.pkt_valid !== 1'b1 || bus.pkt_len !== 5'd1) begin n_fail++; $display("FAIL midreset_frame got valid %b len %0d want 1/1", bus.pkt_valid, bus.pkt_len); end
      n_chk++; if (bus.rd_data !== 8'h7E) begin n_fail++; $display("FAIL midreset_rd got %h want 7e", bus.rd_data); end
      do_ack();
   endtask

   initial begin
      test_reset();
      test_good_frame();
      test_bad_csum();
      test_len_bounds();
      test_timeout();
      test_overrun();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
